// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bus: the fetch unit is the master, imem is the slave.
interface instruction_fetch_unit_if #(
  parameter int unsigned data_bits = 32
);
  logic                 req;
  logic [data_bits-1:0] addr;
  logic                 ack;
  logic [data_bits-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF-stage producer: owns the fetch PC, runs req/ack with imem, handles stall and redirect.
// Optional misaligned-redirect trap enabled by defining MISALIGN_TRAP_EN.
//
//  state | meaning
//  REQ   | request outstanding at fetch_pc
//  HOLD  | fetched word parked (or trap parked) waiting for downstream; no request
//  DRAIN | redirected while request in flight; wait for its ack, then go to pending_pc
module instruction_fetch_unit #(
  parameter int unsigned          data_bits = 32,
  parameter logic [data_bits-1:0] reset_pc  = '0,
  parameter int unsigned          pc_step   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pc_write_enable,
  input  logic                     redirect_enable,
  input  logic [data_bits-1:0]     redirect_pc,
  instruction_fetch_unit_if.master imem,
  output logic [data_bits-1:0]     pc_out,
  output logic [data_bits-1:0]     instruction_out,
  output logic                     instruction_valid
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                     fetch_misaligned
`endif
);

  typedef enum logic [1:0] {REQ = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [data_bits-1:0] step = data_bits'(pc_step);

  state_t               state_q, state_d;
  logic [data_bits-1:0] fetch_pc_q, fetch_pc_d, pending_q, pending_d;
  logic [data_bits-1:0] hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
  logic [data_bits-1:0] pc_out_q, pc_out_d, instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 ack_live, do_launch;
  logic [data_bits-1:0] redir_tgt, launch_tgt;

`ifdef MISALIGN_TRAP_EN
  localparam logic [data_bits-1:0] nop = data_bits'(32'h0000_0013);
  logic trapped_q, trapped_d, hold_full_q, hold_full_d, mis_q, mis_d;
  assign redir_tgt = redirect_pc;
`else
  assign redir_tgt = redirect_pc & ~data_bits'(3);
`endif

  // An ack only counts while a request is actually on the bus.
  assign ack_live = imem.ack && (state_q != HOLD);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    hold_pc_d  = hold_pc_q;
    hold_instr_d = hold_instr_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    do_launch  = 1'b0;
    launch_tgt = redir_tgt;
`ifdef MISALIGN_TRAP_EN
    trapped_d   = trapped_q;
    hold_full_d = hold_full_q;
    mis_d       = mis_q;
`endif
    if (redirect_enable) begin
      valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trapped_d   = 1'b0;
      hold_full_d = 1'b0;
      mis_d       = 1'b0;
`endif
      if (state_q == REQ && !ack_live) begin
        pending_d = redir_tgt;
        state_d   = DRAIN;
      end else if (state_q == DRAIN && !ack_live) begin
        pending_d = redir_tgt;
      end else begin
        do_launch = 1'b1;
      end
    end else begin
      unique case (state_q)
        REQ: begin
          if (ack_live) begin
            fetch_pc_d = fetch_pc_q + step;
            if (pc_write_enable) begin
              pc_out_d = fetch_pc_q;
              instr_d  = imem.rdata;
              valid_d  = 1'b1;
`ifdef MISALIGN_TRAP_EN
              mis_d    = 1'b0;
`endif
            end else begin
              hold_pc_d    = fetch_pc_q;
              hold_instr_d = imem.rdata;
              state_d      = HOLD;
`ifdef MISALIGN_TRAP_EN
              hold_full_d  = 1'b1;
`endif
            end
          end else if (pc_write_enable) begin
            valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_d   = 1'b0;
`endif
          end
        end
        HOLD: begin
          if (pc_write_enable) begin
`ifdef MISALIGN_TRAP_EN
            if (hold_full_q) begin
              pc_out_d    = hold_pc_q;
              instr_d     = hold_instr_q;
              valid_d     = 1'b1;
              mis_d       = trapped_q;
              hold_full_d = 1'b0;
              state_d     = trapped_q ? HOLD : REQ;
            end else begin
              valid_d = 1'b0;
              mis_d   = 1'b0;
            end
`else
            pc_out_d = hold_pc_q;
            instr_d  = hold_instr_q;
            valid_d  = 1'b1;
            state_d  = REQ;
`endif
          end
        end
        DRAIN: begin
          if (ack_live) begin
            do_launch  = 1'b1;
            launch_tgt = pending_q;
          end
        end
        default: state_d = REQ;
      endcase
    end
    // Start fetching from a new target; a misaligned target parks a NOP instead.
    if (do_launch) begin
`ifdef MISALIGN_TRAP_EN
      if (launch_tgt[1:0] != 2'b00) begin
        hold_pc_d    = launch_tgt;
        hold_instr_d = nop;
        trapped_d    = 1'b1;
        hold_full_d  = 1'b1;
        state_d      = HOLD;
      end else begin
        fetch_pc_d = launch_tgt;
        state_d    = REQ;
      end
`else
      fetch_pc_d = launch_tgt;
      state_d    = REQ;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      fetch_pc_q   <= reset_pc;
      pending_q    <= reset_pc;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      pc_out_q     <= '0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      trapped_q    <= 1'b0;
      hold_full_q  <= 1'b0;
      mis_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      pc_out_q     <= pc_out_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
`ifdef MISALIGN_TRAP_EN
      trapped_q    <= trapped_d;
      hold_full_q  <= hold_full_d;
      mis_q        <= mis_d;
`endif
    end
  end

  assign imem.req          = (state_q != HOLD);
  assign imem.addr         = fetch_pc_q;
  assign pc_out            = pc_out_q;
  assign instruction_out   = instr_q;
  assign instruction_valid = valid_q;
`ifdef MISALIGN_TRAP_EN
  assign fetch_misaligned  = mis_q;
`endif

endmodule
